adc_ram_reader: RTL and testbench

Drains the 32-bit ADC accumulation RAM after a capture run and streams each word to the host side over a valid/ready handshake, optionally scaled down by a power of two to turn sums into averages. It sits on the second port of the same 4096×32 accumulation RAM that the ADC capture path fills, and runs between capture runs. When clear-on-read is compiled in, it also writes zero back to each word, so the next capture run accumulates from zero.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_ram_reader_if.sv | 38 +++
 rtl/adc_ram_reader.sv | 147 ++++++++++++++
 tb/tb_adc_ram_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Definitions shared by the ADC accumulation RAM capture and readout paths.
package adc_pkg;

    localparam int ADC_RAM_ADDR_W = 12;
    localparam int ADC_RAM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OUT,
        CLR,
        FIN
    } adc_rd_state_t;

endpackage

// File: rtl/adc_ram_reader_if.sv
// RAM second-port and output-stream signals of the accumulation RAM reader.
interface adc_ram_reader_if #(
    parameter int ADDR_W = adc_pkg::ADC_RAM_ADDR_W,
    parameter int DATA_W = adc_pkg::ADC_RAM_DATA_W
) ();

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_wr_data,
        output out_data,
        output out_valid,
        output out_last,
        input  ram_rd_data,
        input  out_ready
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_wr_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output ram_rd_data,
        output out_ready
    );

endinterface

// File: rtl/adc_ram_reader.sv
// Drains the ADC accumulation RAM to a valid/ready stream, each word shifted right by avg_shift.
// Define ADC_READER_CLEAR_EN to zero every word in RAM after it has been handed off.
module adc_ram_reader
    import adc_pkg::*;
#(
    parameter int ADDR_W = ADC_RAM_ADDR_W,
    parameter int DATA_W = ADC_RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    input  logic [4:0]        avg_shift,
    output logic              busy,
    output logic              done,
    adc_ram_reader_if.master  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    adc_rd_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [4:0]        shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              last_word;
    logic              decide;
    logic [DATA_W-1:0] scaled;

    assign xfer      = valid_q && bus.out_ready;
    assign last_word = (cnt_q == '0);
    assign scaled    = (32'(shift_q) >= 32'(DATA_W)) ? '0 : (bus.ram_rd_data >> shift_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        decide  = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q high means this is the cycle right after a drain; start is dropped there
                if (start && !done_q) begin
                    shift_d = avg_shift;
                    addr_d  = '0;
                    cnt_d   = length - ADDR_ONE;
                    busy_d  = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                data_d  = scaled;
                valid_d = 1'b1;
                last_d  = last_word;
                state_d = OUT;
            end
            OUT: begin
                if (xfer) begin
                    valid_d = 1'b0;
`ifdef ADC_READER_CLEAR_EN
                    state_d = CLR;
`else
                    decide  = 1'b1;
`endif
                end
            end
`ifdef ADC_READER_CLEAR_EN
            CLR: begin
                decide = 1'b1;
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            if (last_word) begin
                state_d = FIN;
            end else begin
                addr_d  = addr_q + ADDR_ONE;
                cnt_d   = cnt_q - ADDR_ONE;
                state_d = RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Write strobe decodes straight from the state register so reset kills it at once
`ifdef ADC_READER_CLEAR_EN
    assign bus.ram_we = (state_q == CLR);
`else
    assign bus.ram_we = 1'b0;
`endif

    assign bus.ram_wr_data = '0;
    assign bus.ram_addr    = addr_q;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_last    = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_adc_ram_reader.sv
// Directed self-checking bench for adc_ram_reader with a registered-read RAM model.
module tb_adc_ram_reader;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] length;
    logic [4:0]    avg_shift;
    logic          busy;
    logic          done;

    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [DW-1:0] tb_wdata;

    logic [DW-1:0] mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    logic [AW-1:0] q_addr [$];
    int            we_count   = 0;
    int            done_count = 0;
    int            hold_err   = 0;
    logic          prev_hold  = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    adc_ram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    adc_ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .length    (length),
        .avg_shift (avg_shift),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.ram_rd_data <= mem[bus.ram_addr];
        if (tb_we)
            mem[tb_waddr] <= tb_wdata;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wr_data;
    end

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_addr.push_back(bus.ram_addr);
        end
        if (bus.ram_we === 1'b1) we_count <= we_count + 1;
        if (done === 1'b1) done_count <= done_count + 1;
        if (rst === 1'b1) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data))
                hold_err <= hold_err + 1;
            prev_hold <= (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_data <= bus.out_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input int a, input logic [DW-1:0] d);
        tb_we    = 1'b1;
        tb_waddr = AW'(a);
        tb_wdata = d;
        tick();
        tb_we    = 1'b0;
    endtask

    task automatic start_drain(input int len, input int sh);
        length    = AW'(len);
        avg_shift = 5'(sh);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (done === 1'b1) break;
        end
        check({tag, " done seen"}, 64'(done), 64'(1));
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (bus.out_valid === 1'b1) break;
        end
        check({tag, " valid seen"}, 64'(bus.out_valid), 64'(1));
    endtask

    initial begin
        int base, d0, w0, errs_a, errs_d, n_last, max_a, n;
        logic [DW-1:0] exp_w;
        logic [DW-1:0] run1 [4];

        rst = 1'b1; start = 1'b0; length = '0; avg_shift = '0;
        bus.out_ready = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        tick(); tick();

        // reset values while rst is held
        check("rst ram_addr",  64'(bus.ram_addr),  64'(0));
        check("rst out_valid", 64'(bus.out_valid), 64'(0));
        check("rst out_last",  64'(bus.out_last),  64'(0));
        check("rst out_data",  64'(bus.out_data),  64'(0));
        check("rst busy",      64'(busy),          64'(0));
        check("rst done",      64'(done),          64'(0));
        check("rst ram_we",    64'(bus.ram_we),    64'(0));
        rst = 1'b0;
        tick();

        // basic 4-word drain, no shift
        ram_write(0, 10); ram_write(1, 20); ram_write(2, 30); ram_write(3, 40);
        bus.out_ready = 1'b1;
        base = q_data.size(); d0 = done_count; w0 = we_count;
        start_drain(4, 0);
        check("t1 busy after start", 64'(busy), 64'(1));
        check("t1 addr after start", 64'(bus.ram_addr), 64'(0));
        wait_done(100, "t1");
        tick();
        check("t1 word count", 64'(q_data.size() - base), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1 data[%0d]", i), 64'(q_data[base+i]), 64'((i + 1) * 10));
            check($sformatf("t1 last[%0d]", i), 64'(q_last[base+i]), 64'(i == 3));
        end
        check("t1 done pulses", 64'(done_count - d0), 64'(1));
        for (int i = 0; i < 4; i++) begin
`ifdef ADC_READER_CLEAR_EN
            check($sformatf("t1 ram[%0d] after", i), 64'(mem[i]), 64'(0));
`else
            check($sformatf("t1 ram[%0d] after", i), 64'(mem[i]), 64'((i + 1) * 10));
`endif
        end
`ifdef ADC_READER_CLEAR_EN
        check("t1 ram writes", 64'(we_count - w0), 64'(4));
`else
        check("t1 ram writes", 64'(we_count - w0), 64'(0));
`endif
        $display("t1 drain len=4 shift=0 words=%0d", q_data.size() - base);

        // single word, shift 3, first-word latency
        ram_write(0, 32'h0000_0140);
        base = q_data.size();
        start_drain(1, 3);
        check("t2 valid after edge0", 64'(bus.out_valid), 64'(0));
        tick();
        check("t2 valid after edge1", 64'(bus.out_valid), 64'(0));
        tick();
        check("t2 valid after edge2", 64'(bus.out_valid), 64'(1));
        check("t2 out_data", 64'(bus.out_data), 64'(32'h28));
        check("t2 out_last", 64'(bus.out_last), 64'(1));
        wait_done(50, "t2");
        tick();
        check("t2 word count", 64'(q_data.size() - base), 64'(1));
        $display("t2 drain len=1 shift=3 word=0x%0h", q_data[base]);

        // maximum shift
        ram_write(0, 32'hFFFF_FFFF);
        start_drain(1, 31);
        wait_valid(10, "t2b");
        check("t2b out_data shift31", 64'(bus.out_data), 64'(1));
        wait_done(50, "t2b");
        tick();
        $display("t2b drain len=1 shift=31 word=0x%0h", q_data[q_data.size()-1]);

        // length 0 means the full depth
        for (int i = 0; i < DEPTH; i++) ram_write(i, 32'h1000_0000 + 32'(i) * 7);
        base = q_data.size(); w0 = we_count;
        start_drain(0, 2);
        wait_done(20000, "t3");
        tick();
        n = q_data.size() - base;
        check("t3 word count", 64'(n), 64'(DEPTH));
        if (n > DEPTH) n = DEPTH;
        errs_a = 0; errs_d = 0; n_last = 0; max_a = 0;
        for (int i = 0; i < n; i++) begin
            exp_w = (32'h1000_0000 + 32'(i) * 7) >> 2;
            if (q_addr[base+i] !== AW'(i)) errs_a++;
            if (q_data[base+i] !== exp_w) errs_d++;
            if (q_last[base+i] === 1'b1) n_last++;
            if (int'(q_addr[base+i]) > max_a) max_a = int'(q_addr[base+i]);
        end
        check("t3 addr sequence errors", 64'(errs_a), 64'(0));
        check("t3 data errors", 64'(errs_d), 64'(0));
        check("t3 last count", 64'(n_last), 64'(1));
        check("t3 last flag on final", 64'(q_last[base+DEPTH-1]), 64'(1));
        check("t3 final addr", 64'(q_addr[base+DEPTH-1]), 64'(DEPTH - 1));
        check("t3 max addr", 64'(max_a), 64'(DEPTH - 1));
`ifdef ADC_READER_CLEAR_EN
        check("t3 ram writes", 64'(we_count - w0), 64'(DEPTH));
`else
        check("t3 ram writes", 64'(we_count - w0), 64'(0));
`endif
        $display("t3 drain len=0 shift=2 words=%0d", q_data.size() - base);

        // backpressure on the second word
        ram_write(0, 32'h100); ram_write(1, 32'h200); ram_write(2, 32'h300); ram_write(3, 32'h400);
        bus.out_ready = 1'b0;
        base = q_data.size(); w0 = we_count;
        start_drain(4, 4);
        wait_valid(10, "t4 w0");
        check("t4 w0 data", 64'(bus.out_data), 64'(32'h10));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_valid(10, "t4 w1");
        d0 = we_count;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t4 hold valid c%0d", k), 64'(bus.out_valid), 64'(1));
            check($sformatf("t4 hold data c%0d", k), 64'(bus.out_data), 64'(32'h20));
        end
        check("t4 no write while held", 64'(we_count - d0), 64'(0));
        bus.out_ready = 1'b1;
        wait_done(100, "t4");
        tick();
        check("t4 word count", 64'(q_data.size() - base), 64'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("t4 data[%0d]", i), 64'(q_data[base+i]), 64'((i + 1) * 16));
        check("t4 hold violations", 64'(hold_err), 64'(0));
`ifdef ADC_READER_CLEAR_EN
        check("t4 ram writes", 64'(we_count - w0), 64'(4));
`else
        check("t4 ram writes", 64'(we_count - w0), 64'(0));
`endif
        $display("t4 drain len=4 shift=4 backpressure words=%0d", q_data.size() - base);

        // start while busy is ignored
        for (int i = 0; i < 8; i++) ram_write(i, 32'(i + 1));
        base = q_data.size();
        start_drain(4, 0);
        tick(); tick();
        start_drain(8, 1);
        check("t5a busy after stray start", 64'(busy), 64'(1));
        wait_done(100, "t5a");
        tick();
        check("t5a word count", 64'(q_data.size() - base), 64'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("t5a data[%0d]", i), 64'(q_data[base+i]), 64'(i + 1));
        check("t5a final addr", 64'(q_addr[base+3]), 64'(3));
        $display("t5a drain len=4 with stray start words=%0d", q_data.size() - base);

        // reset while word 2 of 4 is pending
        ram_write(0, 32'h11); ram_write(1, 32'h22); ram_write(2, 32'h33); ram_write(3, 32'h44);
        bus.out_ready = 1'b0;
        base = q_data.size(); d0 = done_count;
        start_drain(4, 0);
        wait_valid(10, "t5b w0");
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        wait_valid(10, "t5b w1");
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        wait_valid(10, "t5b w2");
        #2 rst = 1'b1;
        #1;
        check("t5b rst out_valid", 64'(bus.out_valid), 64'(0));
        check("t5b rst out_data",  64'(bus.out_data),  64'(0));
        check("t5b rst out_last",  64'(bus.out_last),  64'(0));
        check("t5b rst busy",      64'(busy),          64'(0));
        check("t5b rst ram_addr",  64'(bus.ram_addr),  64'(0));
        check("t5b rst ram_we",    64'(bus.ram_we),    64'(0));
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("t5b words before reset", 64'(q_data.size() - base), 64'(2));
        check("t5b no done", 64'(done_count - d0), 64'(0));
        check("t5b busy stays low", 64'(busy), 64'(0));
        check("t5b ram[2] kept", 64'(mem[2]), 64'(32'h33));
        check("t5b ram[3] kept", 64'(mem[3]), 64'(32'h44));
`ifdef ADC_READER_CLEAR_EN
        check("t5b ram[1] cleared", 64'(mem[1]), 64'(0));
`else
        check("t5b ram[1] kept", 64'(mem[1]), 64'(32'h22));
`endif
        $display("t5b drain len=4 reset at word 2 words=%0d", q_data.size() - base);

        // repeated drain; start in the done cycle is ignored
        ram_write(0, 7); ram_write(1, 8); ram_write(2, 9); ram_write(3, 10);
        bus.out_ready = 1'b1;
        base = q_data.size(); w0 = we_count;
        start_drain(4, 1);
        wait_done(100, "t6 run1");
        start_drain(4, 1);
        check("t6 start in done cycle ignored", 64'(busy), 64'(0));
        start_drain(4, 1);
        check("t6 second start accepted", 64'(busy), 64'(1));
        wait_done(100, "t6 run2");
        tick();
        check("t6 word count", 64'(q_data.size() - base), 64'(8));
        run1[0] = 3; run1[1] = 4; run1[2] = 4; run1[3] = 5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6 run1[%0d]", i), 64'(q_data[base+i]), 64'(run1[i]));
`ifdef ADC_READER_CLEAR_EN
            check($sformatf("t6 run2[%0d]", i), 64'(q_data[base+4+i]), 64'(0));
`else
            check($sformatf("t6 run2[%0d]", i), 64'(q_data[base+4+i]), 64'(run1[i]));
`endif
        end
`ifdef ADC_READER_CLEAR_EN
        check("t6 ram writes", 64'(we_count - w0), 64'(8));
`else
        check("t6 ram writes", 64'(we_count - w0), 64'(0));
        check("total ram writes", 64'(we_count), 64'(0));
`endif
        $display("t6 two drains len=4 shift=1 words=%0d", q_data.size() - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
